// File: rtl/llr_frame_buffer_ctrl.sv
// Frame buffer controller: fills a single-port RAM with one codeword of LLRs,
// then drains it in address order through a 2-entry buffer that hides the RAM read latency.
module llr_frame_buffer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]         out_cnt_q, out_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  pend_last_q, pend_last_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [DATA_WIDTH-1:0] fifo_data_d [2];
    logic [1:0]            fifo_last_q, fifo_last_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            buf_count_q, buf_count_d;

    logic       pop;
    logic       push;
    logic       rd_issue;
    logic [2:0] occ_after;

    always_comb begin
        // NOTE: every output and next-state signal gets a default first, so no path can infer a latch.
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_cnt_d   = out_cnt_q;
        pend_last_d = pend_last_q;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        in_ready    = 1'b0;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_address = wr_cnt_q[ADDR_WIDTH-1:0];
        ram_data_in = in_data;
        rd_issue    = 1'b0;

        out_valid = (buf_count_q != 2'd0);
        out_data  = fifo_data_q[rd_ptr_q];
        out_last  = fifo_last_q[rd_ptr_q];
        pop       = out_valid && out_ready;
        push      = rd_pend_q;
        // Occupancy the buffer will have once the in-flight read lands and this cycle's pop leaves.
        occ_after = 3'(buf_count_q) + 3'(rd_pend_q) - 3'(pop);

        unique case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ram_cs = 1'b1;
                    ram_we = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d  = DRAIN;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                ram_address = rd_cnt_q[ADDR_WIDTH-1:0];
                rd_issue    = (rd_cnt_q < FRAME_CNT) && (occ_after < 3'd2);
                if (rd_issue) begin
                    ram_cs      = 1'b1;
                    rd_cnt_d    = rd_cnt_q + 1'b1;
                    pend_last_d = (rd_cnt_q == LAST_IDX);
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_last) begin
                        state_d   = FILL;
                        rd_cnt_d  = '0;
                        out_cnt_d = '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        rd_pend_d = rd_issue;

        if (push) begin
            fifo_data_d[wr_ptr_q] = ram_data_out;
            fifo_last_d[wr_ptr_q] = pend_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push, pop})
            2'b10:   buf_count_d = buf_count_q + 2'd1;
            2'b01:   buf_count_d = buf_count_q - 2'd1;
            default: buf_count_d = buf_count_q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            rd_pend_q   <= 1'b0;
            pend_last_q <= 1'b0;
            // NOTE: the two buffer entries are reset because the head drives out_data, which must read 0 out of reset.
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            buf_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_cnt_q   <= out_cnt_d;
            rd_pend_q   <= rd_pend_d;
            pend_last_q <= pend_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_count_q <= buf_count_d;
        end
    end

endmodule

// File: doc/llr_frame_buffer_ctrl.md
# llr_frame_buffer_ctrl

Controller between the channel-LLR input stream and the single-port synchronous RAM that holds one codeword. It alternates between filling the RAM with FRAME_LEN words from a valid/ready input stream and draining them in address order to the decoder over a valid/ready output stream. It generates the RAM's cs/we/address/data_in and absorbs the RAM's one-cycle read latency with a 2-entry output buffer, so the drain runs at one word per cycle under no backpressure.

## Interface
- DATA_WIDTH, 8, LLR word width; equals RAM data width
- ADDR_WIDTH, 8, RAM address width
- FRAME_LEN, 256, words per codeword; legal range 2..2^ADDR_WIDTH
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  input LLR word
- out_valid  out  1  output word valid
- out_ready  in  1  consumer ready; transfer on out_valid && out_ready
- out_data  out  DATA_WIDTH  output LLR word
- out_last  out  1  high with the word from address FRAME_LEN-1
- ram_cs  out  1  to RAM chip select
- ram_we  out  1  to RAM write enable
- ram_address  out  ADDR_WIDTH  to RAM address
- ram_data_in  out  DATA_WIDTH  to RAM write data
- ram_data_out  in  DATA_WIDTH  from RAM; valid the cycle after a read is issued

## Operation
- Two states: FILL, DRAIN. Reset state FILL.
- Counters: wr_cnt, rd_cnt (read addresses issued), each ADDR_WIDTH+1 bits wide; out_cnt (words popped).
- FILL: in_ready=1. Each accepted word: ram_cs=1, ram_we=1, ram_address=wr_cnt, ram_data_in=in_data, wr_cnt++. On accepting the word with wr_cnt==FRAME_LEN-1, go to DRAIN and clear wr_cnt. When no word is accepted: ram_cs=0, ram_we=0.
- DRAIN: in_ready=0, ram_we=0.
- Read pending: rd_pend is set in the cycle after a read is issued.
- Buffer: 2-entry FIFO. buf_count is 0..2. pop = out_valid && out_ready.
- A read is issued (ram_cs=1, ram_address=rd_cnt, rd_cnt++) in a cycle when both hold:
  - rd_cnt < FRAME_LEN
  - buf_count + rd_pend - pop < 2
- When rd_pend=1, ram_data_out is written into the FIFO at that cycle's edge.
- out_valid = (buf_count != 0). out_data and out_last come from the FIFO head. The last flag is stored alongside each word and is set for address FRAME_LEN-1.
- On a pop with out_last=1, go to FILL. At the same edge clear rd_cnt and out_cnt; the FIFO is empty at that point.
- A push and a pop in the same cycle are both honoured.
- ram_data_in is don't-care whenever ram_we=0; drive it with in_data.
- Reset mid-operation: the next state is FILL, all counters are 0, the FIFO is emptied, rd_pend=0, and any partial frame is discarded. RAM contents are not cleared; they are overwritten by the next fill.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, ram_cs=0, ram_we=0, ram_address=0, ram_data_in=in_data.
- Write latency: word accepted in cycle t is written at the edge ending cycle t.
- The FILL→DRAIN edge is the one on which the last word is accepted. The first read is issued in DRAIN cycle d0.
- ram_data_out is valid in d1 and pushed at the end of d1. out_valid first rises in d2.
- With out_ready held at 1: one word per cycle from d2 through d(FRAME_LEN+1), and out_last=1 in d(FRAME_LEN+1).
- With FILL fed every cycle, a full frame cycle is FRAME_LEN fill cycles plus FRAME_LEN+2 drain cycles.
- DRAIN→FILL happens at the edge of the out_last handshake. in_ready=1 in the following cycle.
- Backpressure: while out_ready=0, at most 2 words are buffered. No read is issued that would overflow the FIFO. Order and data are preserved, with no loss or duplication.
- out_valid, out_data and out_last are stable while out_valid && !out_ready.

## Test plan
- Reset, FRAME_LEN=4. Feed 0x11,0x22,0x33,0x44 back-to-back with in_valid=1 and out_ready=1.
  - Writes occur to addresses 0..3.
  - out_data=0x11,0x22,0x33,0x44 on consecutive cycles starting 2 cycles after entry to DRAIN, with out_last only on 0x44.
  - in_ready=1 on the cycle after.
- Same frame with out_ready=0 for 5 cycles after out_valid first rises:
  - exactly 2 reads are issued and out_data holds 0x11;
  - on release, the full sequence arrives with no loss or duplication.
- in_valid toggled 1,0,1,0 during FILL:
  - wr_cnt advances only on handshakes;
  - ram_cs=0 on idle cycles;
  - DRAIN is entered only after the 4th accepted word.
- Assert rst_n=0 after 2 of 4 words are written:
  - the next cycle shows FILL with wr_cnt=0;
  - a new frame 0xA0..0xA3 is output exactly, with no stale words.
- Two consecutive frames with random out_ready (50%):
  - out_data matches a scoreboard;
  - out_last appears once per frame;
  - in_ready=0 throughout DRAIN.
- FRAME_LEN=2^ADDR_WIDTH (256):
  - addresses 0..255 are each written and read exactly once;
  - the counters do not wrap before the frame ends.
